// File: rtl/tdr_pkg.sv
// Shared types and helpers for the TDR far-end reflection engine.
// Default widths here define the build; the top-level parameters default to them.
package tdr_pkg;

  localparam int DEF_DATA_W    = 12;
  localparam int DEF_COEF_W    = 8;
  localparam int DEF_NUM_TAPS  = 4;
  localparam int DEF_MAX_DELAY = 256;
  localparam int DEF_ADDR_W    = $clog2(DEF_MAX_DELAY);
  localparam int DEF_SUM_W     = DEF_DATA_W + DEF_COEF_W + $clog2(DEF_NUM_TAPS);

  typedef logic signed [DEF_DATA_W-1:0] sample_t;
  typedef logic signed [DEF_COEF_W-1:0] coef_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2
  } state_t;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] delay;
    coef_t                 coef;
  } tap_cfg_t;

  localparam logic signed [DEF_SUM_W-1:0] SAT_MAX = DEF_SUM_W'((1 << (DEF_DATA_W - 1)) - 1);
  localparam logic signed [DEF_SUM_W-1:0] SAT_MIN = ~SAT_MAX;

  // Clamp a scaled tap sum into the sample range and report whether it clipped.
  function automatic sample_t saturate(input logic signed [DEF_SUM_W-1:0] v,
                                       output logic clamped);
    clamped = 1'b0;
    if (v > SAT_MAX) begin
      clamped = 1'b1;
      return SAT_MAX[DEF_DATA_W-1:0];
    end
    if (v < SAT_MIN) begin
      clamped = 1'b1;
      return SAT_MIN[DEF_DATA_W-1:0];
    end
    return v[DEF_DATA_W-1:0];
  endfunction

endpackage

// File: rtl/tdr_delay_line.sv
// Circular sample buffer: one write port (sample or flush zero), NUM_TAPS
// asynchronous read ports addressed relative to the write pointer.
module tdr_delay_line #(
  parameter int DATA_W    = 12,
  parameter int NUM_TAPS  = 4,
  parameter int MAX_DELAY = 256,
  parameter int ADDR_W    = $clog2(MAX_DELAY)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic [ADDR_W-1:0]                  flush_addr,
  input  logic                               push,
  input  logic [DATA_W-1:0]                  push_data,
  input  logic [NUM_TAPS-1:0][ADDR_W-1:0]    rd_delay,
  output logic [NUM_TAPS-1:0][DATA_W-1:0]    rd_data
);

  logic [DATA_W-1:0] mem [MAX_DELAY];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
    end else if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    we    = flush || push;
    waddr = flush ? flush_addr : wr_ptr_q;
    wdata = flush ? '0 : push_data;
  end

  // Reads see the contents before this cycle's write lands.
  always_comb begin
    for (int i = 0; i < NUM_TAPS; i++) begin
      rd_data[i] = mem[ADDR_W'(wr_ptr_q - rd_delay[i])];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // NOTE: the storage array has no reset; the FLUSH sweep is what clears it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/tdr_reflection_engine.sv
// Far-end termination model: delayed, coefficient-scaled echoes of the incident
// samples summed into one saturated reflected sample, two-stage pipeline.
module tdr_reflection_engine
  import tdr_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int COEF_W    = DEF_COEF_W,
  parameter int NUM_TAPS  = DEF_NUM_TAPS,
  parameter int MAX_DELAY = DEF_MAX_DELAY,
  parameter int ADDR_W    = $clog2(MAX_DELAY)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          in_valid,
  input  logic signed [DATA_W-1:0]      in_sample,
  input  logic                          cfg_we,
  input  logic [$clog2(NUM_TAPS)-1:0]   cfg_tap,
  input  logic [ADDR_W-1:0]             cfg_delay,
  input  logic signed [COEF_W-1:0]      cfg_coef,
  input  logic                          cfg_commit,
  output logic                          busy,
  output logic                          out_valid,
  output logic signed [DATA_W-1:0]      out_sample,
  output logic                          sat_flag
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int SUM_W  = PROD_W + $clog2(NUM_TAPS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_DELAY - 1);

  state_t                      state_q, state_d;
  logic [ADDR_W-1:0]           flush_cnt_q, flush_cnt_d;
  tap_cfg_t [NUM_TAPS-1:0]     shadow_q, shadow_d, active_q, active_d;
  logic                        valid1_q, valid1_d;
  logic signed [PROD_W-1:0]    prod_q [NUM_TAPS];
  logic signed [PROD_W-1:0]    prod_d [NUM_TAPS];
  logic                        out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0]    out_sample_q, out_sample_d;
  logic                        sat_q, sat_d;

  logic                        flushing, accept, run_next, clamped;
  logic signed [SUM_W-1:0]     sum, sum_shr;
  logic signed [DATA_W-1:0]    sat_sample;
  logic [NUM_TAPS-1:0][ADDR_W-1:0] rd_delay;
  logic [NUM_TAPS-1:0][DATA_W-1:0] rd_data;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    flushing    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d     = FLUSH;
          flush_cnt_d = '0;
        end
      end
      FLUSH: begin
        flushing    = 1'b1;
        flush_cnt_d = flush_cnt_q + 1'b1;
        if (!enable) begin
          state_d = IDLE;
        end else if (flush_cnt_q == LAST_ADDR) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept   = (state_q == RUN) && enable && in_valid;
  assign run_next = (state_d == RUN);

  // A commit copies the shadow as it stood before any same-cycle write.
  always_comb begin
    shadow_d = shadow_q;
    if (cfg_we) begin
      shadow_d[cfg_tap].delay = cfg_delay;
      shadow_d[cfg_tap].coef  = cfg_coef;
    end
    active_d = cfg_commit ? shadow_q : active_q;
  end

  always_comb begin
    valid1_d = accept && run_next;
    for (int i = 0; i < NUM_TAPS; i++) begin
      rd_delay[i] = active_q[i].delay;
      if (active_q[i].delay == '0) begin
        prod_d[i] = '0;
      end else begin
        prod_d[i] = PROD_W'($signed(rd_data[i])) * PROD_W'(active_q[i].coef);
      end
    end
  end

  // Leaving RUN drops whatever is still in the pipeline.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      sum = sum + SUM_W'(prod_q[i]);
    end
    sum_shr      = sum >>> (COEF_W - 1);
    sat_sample   = saturate(sum_shr, clamped);
    out_valid_d  = valid1_q && run_next;
    out_sample_d = out_valid_d ? sat_sample : out_sample_q;
    sat_d        = (sat_q && !cfg_commit) || (out_valid_d && clamped);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      flush_cnt_q  <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      valid1_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
      sat_q        <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        prod_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      valid1_q     <= valid1_d;
      out_valid_q  <= out_valid_d;
      out_sample_q <= out_sample_d;
      sat_q        <= sat_d;
      for (int i = 0; i < NUM_TAPS; i++) begin
        prod_q[i] <= prod_d[i];
      end
    end
  end

  tdr_delay_line #(
    .DATA_W    (DATA_W),
    .NUM_TAPS  (NUM_TAPS),
    .MAX_DELAY (MAX_DELAY),
    .ADDR_W    (ADDR_W)
  ) u_delay_line (
    .clk        (clk),
    .rst        (rst),
    .flush      (flushing),
    .flush_addr (flush_cnt_q),
    .push       (accept),
    .push_data  (in_sample),
    .rd_delay   (rd_delay),
    .rd_data    (rd_data)
  );

  assign busy       = (state_q == FLUSH);
  assign out_valid  = out_valid_q;
  assign out_sample = out_sample_q;
  assign sat_flag   = sat_q;

endmodule
